// File: rtl/spi_multi_reader_pkg.sv
// Shared state encoding and width helper for the multi-channel SPI reader.
// Pure declarations: no latency, no backpressure.
package spi_multi_reader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_SHIFT = 2'd2,
        ST_GAP   = 2'd3
    } state_t;

    // Bits needed to index n items, never less than one.
    function automatic int clog2_min1(input int n);
        int w;
        w = 0;
        while ((1 << w) < n) w++;
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/spi_multi_reader_if.sv
// Control, serial and sample signals of the SPI reader; master = reader side.
// No latency, no backpressure: a plain bundle of wires.
interface spi_multi_reader_if #(
    parameter int N_CH   = 1,
    parameter int DATA_W = 8,
    parameter int CH_W   = 1
);
    logic              sw;
    logic              start;
    logic              sdo;
    logic              scl;
    logic [N_CH-1:0]   cs;
    logic [DATA_W-1:0] out;
    logic [CH_W-1:0]   out_ch;
    logic              valid;
    logic              busy;

    modport master (
        input  sw, start, sdo,
        output scl, cs, out, out_ch, valid, busy
    );

    modport slave (
        output sw, start, sdo,
        input  scl, cs, out, out_ch, valid, busy
    );
endinterface

// File: rtl/spi_clk_div.sv
// Half-period tick generator: tick every CLK_DIV clks while en, counter held at 0 otherwise.
// Tick is combinational from the counter; no backpressure.
module spi_clk_div #(
    parameter int CLK_DIV = 50
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tick
);
    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [CW-1:0] r_cnt;
    logic          w_last;

    assign w_last = (r_cnt == CW'(CLK_DIV - 1));
    assign tick   = en && w_last;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (!en || w_last) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CW'(1);
        end
    end
endmodule

// File: rtl/spi_multi_reader.sv
// Round-robin SPI frame reader: one frame per channel, MSB first, field extracted on the last SCL rise.
// Sample valid on the clk edge of the final rise; no backpressure (valid is a one-clk pulse).
module spi_multi_reader
    import spi_multi_reader_pkg::*;
#(
    parameter int FRAME_W  = 16,
    parameter int DATA_MSB = 11,
    parameter int DATA_LSB = 4,
    parameter int CLK_DIV  = 50,
    parameter int N_CH     = 1,
    parameter int GAP      = 4
) (
    input  logic               clk,
    input  logic               rst,
    spi_multi_reader_if.master bus
);
    localparam int DATA_W = DATA_MSB - DATA_LSB + 1;
    localparam int CH_W   = clog2_min1(N_CH);
    localparam int GAP_N  = (GAP < 1) ? 1 : GAP;
    localparam int HC_W   = clog2_min1(2 * FRAME_W + GAP_N + 1);

    if (FRAME_W <= DATA_MSB || DATA_MSB < DATA_LSB || CLK_DIV < 1 || N_CH < 1) begin : g_bad_params
        $error("spi_multi_reader: illegal parameter combination");
    end

    state_t              r_state;
    logic [CH_W-1:0]     r_ch;
    logic [HC_W-1:0]     r_hcnt;
    logic [FRAME_W-1:0]  r_frame;
    logic                r_scl;
    logic [N_CH-1:0]     r_cs;
    logic [DATA_W-1:0]   r_out;
    logic [CH_W-1:0]     r_out_ch;
    logic                r_valid;
    logic                r_busy;

    logic                w_en;
    logic                w_tick;
    logic [FRAME_W:0]    w_shift;
    logic                w_unused_msb;

    assign w_en         = (r_state != ST_IDLE);
    assign w_shift      = {r_frame, bus.sdo};
    assign w_unused_msb = w_shift[FRAME_W];

    spi_clk_div #(
        .CLK_DIV (CLK_DIV)
    ) u_clk_div (
        .clk  (clk),
        .rst  (rst),
        .en   (w_en),
        .tick (w_tick)
    );

    function automatic logic [N_CH-1:0] cs_for(input logic [CH_W-1:0] c);
        logic [N_CH-1:0] v;
        v = '1;
        for (int i = 0; i < N_CH; i++) v[i] = (c != CH_W'(i));
        return v;
    endfunction

    // SHIFT opens with a full high half-period after SETUP, so the 2*FRAME_W
    // toggles end on a rising edge exactly (1+2*FRAME_W) half-periods after cs fell.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= ST_IDLE;
            r_ch     <= '0;
            r_hcnt   <= '0;
            r_frame  <= '0;
            r_scl    <= 1'b1;
            r_cs     <= '1;
            r_out    <= '0;
            r_out_ch <= '0;
            r_valid  <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (bus.sw || bus.start) begin
                        r_state <= ST_SETUP;
                        r_ch    <= '0;
                        r_cs    <= cs_for('0);
                        r_hcnt  <= '0;
                        r_busy  <= 1'b1;
                    end
                end
                ST_SETUP: begin
                    if (w_tick) begin
                        r_state <= ST_SHIFT;
                        r_hcnt  <= '0;
                    end
                end
                ST_SHIFT: begin
                    if (w_tick) begin
                        r_scl  <= ~r_scl;
                        r_hcnt <= r_hcnt + HC_W'(1);
                        if (!r_scl) r_frame <= w_shift[FRAME_W-1:0];
                        if (r_hcnt == HC_W'(2 * FRAME_W - 1)) begin
                            r_state  <= ST_GAP;
                            r_hcnt   <= '0;
                            r_cs     <= '1;
                            r_out    <= w_shift[DATA_MSB:DATA_LSB];
                            r_out_ch <= r_ch;
                            r_valid  <= 1'b1;
                        end
                    end
                end
                ST_GAP: begin
                    if (w_tick) begin
                        if (r_hcnt == HC_W'(GAP_N - 1)) begin
                            r_hcnt <= '0;
                            if (r_ch != CH_W'(N_CH - 1)) begin
                                r_ch    <= r_ch + CH_W'(1);
                                r_cs    <= cs_for(r_ch + CH_W'(1));
                                r_state <= ST_SETUP;
                            end else if (bus.sw) begin
                                r_ch    <= '0;
                                r_cs    <= cs_for('0);
                                r_state <= ST_SETUP;
                            end else begin
                                r_state <= ST_IDLE;
                                r_busy  <= 1'b0;
                            end
                        end else begin
                            r_hcnt <= r_hcnt + HC_W'(1);
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.scl    = r_scl;
    assign bus.cs     = r_cs;
    assign bus.out    = r_out;
    assign bus.out_ch = r_out_ch;
    assign bus.valid  = r_valid;
    assign bus.busy   = r_busy;
endmodule

// File: tb/tb_spi_multi_reader.sv
// Bench for spi_multi_reader: a 3-channel CLK_DIV=2 instance and a 1-channel CLK_DIV=1 instance,
// each with a slave model driving sdo on SCL falling edges.
module tb_spi_multi_reader;

    logic clk;
    logic rst_a;
    logic rst_b;
    int   checks = 0;
    int   errors = 0;

    spi_multi_reader_if #(.N_CH(3), .DATA_W(8), .CH_W(2)) bus_a ();
    spi_multi_reader_if #(.N_CH(1), .DATA_W(8), .CH_W(1)) bus_b ();

    spi_multi_reader #(
        .FRAME_W(16), .DATA_MSB(11), .DATA_LSB(4), .CLK_DIV(2), .N_CH(3), .GAP(4)
    ) dut_a (
        .clk (clk),
        .rst (rst_a),
        .bus (bus_a)
    );

    spi_multi_reader #(
        .FRAME_W(16), .DATA_MSB(11), .DATA_LSB(4), .CLK_DIV(1), .N_CH(1), .GAP(4)
    ) dut_b (
        .clk (clk),
        .rst (rst_b),
        .bus (bus_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // ---------------- channel A: slave frames and reference model ----------------
    logic [15:0] frames_a [3];
    logic [7:0]  log_out [$];
    int          log_ch [$];
    int          exp_ch, cs_low, rises, low_run, vcount_a, last_ch;
    logic [7:0]  last_out;
    logic        prev_scl, prev_cs_high;

    initial begin : slave_a
        int   sel, nbit;
        logic p_scl, p_high;
        sel = 0; nbit = 0; p_scl = 1'b1; p_high = 1'b1;
        bus_a.sdo = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_a) begin
                p_scl = 1'b1; p_high = 1'b1;
            end else begin
                if (bus_a.cs != 3'b111 && p_high) begin
                    for (int i = 0; i < 3; i++) if (!bus_a.cs[i]) sel = i;
                    nbit = 0;
                end
                if (!bus_a.scl && p_scl && bus_a.cs != 3'b111 && nbit < 16) begin
                    bus_a.sdo = frames_a[sel][15 - nbit];
                    nbit++;
                end
                p_scl  = bus_a.scl;
                p_high = (bus_a.cs == 3'b111);
            end
        end
    end

    // Frame-level rules: one cs low at a time, (1+2*16)*2 clks of cs per frame,
    // 16 rises, SCL low for CLK_DIV clks, field = frame[11:4], channels in order, outputs held.
    initial begin : compare_a
        exp_ch = 0; cs_low = 0; rises = 0; low_run = 0; vcount_a = 0;
        last_out = '0; last_ch = 0; prev_scl = 1'b1; prev_cs_high = 1'b1;
        forever begin
            @(negedge clk);
            if (!rst_a) begin
                chk("a_rst_scl", bus_a.scl, 1);
                chk("a_rst_cs", bus_a.cs, 3'b111);
                chk("a_rst_out", bus_a.out, 0);
                chk("a_rst_out_ch", bus_a.out_ch, 0);
                chk("a_rst_valid", bus_a.valid, 0);
                chk("a_rst_busy", bus_a.busy, 0);
                exp_ch = 0; last_out = '0; last_ch = 0; cs_low = 0; rises = 0;
                low_run = 0; prev_scl = 1'b1; prev_cs_high = 1'b1;
            end else begin
                chk("a_cs_onehot0", 32'($onehot0(~bus_a.cs)), 1);
                if (!bus_a.busy) chk("a_idle_lines", {bus_a.scl, bus_a.cs}, 4'hF);
                if (bus_a.cs != 3'b111) begin
                    if (prev_cs_high) begin
                        cs_low = 1; rises = 0; low_run = 0;
                    end else begin
                        cs_low++;
                    end
                end
                if (bus_a.scl && !prev_scl) begin
                    rises++;
                    chk("a_scl_low_half", low_run, 2);
                    low_run = 0;
                end
                if (!bus_a.scl) low_run++;
                if (bus_a.valid) begin
                    chk("a_out", bus_a.out, frames_a[exp_ch][11:4]);
                    chk("a_out_ch", bus_a.out_ch, exp_ch);
                    chk("a_cs_low_len", cs_low, 66);
                    chk("a_rises", rises, 16);
                    log_out.push_back(bus_a.out);
                    log_ch.push_back(int'(bus_a.out_ch));
                    last_out = frames_a[exp_ch][11:4];
                    last_ch  = exp_ch;
                    exp_ch   = (exp_ch + 1) % 3;
                    vcount_a++;
                end else begin
                    chk("a_out_hold", bus_a.out, last_out);
                    chk("a_out_ch_hold", bus_a.out_ch, last_ch);
                end
                prev_scl     = bus_a.scl;
                prev_cs_high = (bus_a.cs == 3'b111);
            end
        end
    end

    // ---------------- channel B: slave plus measurement ----------------
    logic [15:0] frame_b;
    logic        b_ones;
    int          vb, cslb, per_b;

    initial begin : slave_b
        int   nbit, since;
        logic p_scl, p_high;
        nbit = 0; since = 0; p_scl = 1'b1; p_high = 1'b1;
        vb = 0; cslb = 0; per_b = 0;
        bus_b.sdo = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_b) begin
                if (!bus_b.cs[0]) begin
                    if (p_high) begin
                        cslb = 1; nbit = 0;
                    end else begin
                        cslb++;
                    end
                end
                if (!bus_b.scl && p_scl && !bus_b.cs[0] && nbit < 16) begin
                    bus_b.sdo = b_ones ? 1'b1 : frame_b[15 - nbit];
                    nbit++;
                end
                since++;
                if (bus_b.scl && !p_scl) begin
                    per_b = since;
                    since = 0;
                end
                if (bus_b.valid) vb++;
                p_scl  = bus_b.scl;
                p_high = bus_b.cs[0];
            end
        end
    end

    task automatic pulse_a();
        @(posedge clk); #1 bus_a.start = 1'b1;
        @(posedge clk); #1 bus_a.start = 1'b0;
    endtask

    task automatic pulse_b();
        @(posedge clk); #1 bus_b.start = 1'b1;
        @(posedge clk); #1 bus_b.start = 1'b0;
    endtask

    task automatic wait_valid_b(input int budget);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus_b.valid && n < budget);
        chk("b_valid_seen", bus_b.valid, 1);
        #1;
    endtask

    task automatic wait_idle_b(output int n);
        n = 0;
        while (bus_b.busy && n < 50) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic wait_idle_a(input int budget);
        int n;
        n = 0;
        repeat (2) @(negedge clk);
        while (bus_a.busy && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("a_idle_reached", bus_a.busy, 0);
    endtask

    task automatic quiet_a(input string name, input int cycles);
        int q;
        q = 0;
        repeat (cycles) begin
            @(negedge clk);
            if (bus_a.busy || bus_a.cs != 3'b111 || bus_a.valid) q++;
        end
        chk(name, q, 0);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int n, v0;
        rst_a = 1'b0; rst_b = 1'b0;
        bus_a.sw = 1'b0; bus_a.start = 1'b0;
        bus_b.sw = 1'b0; bus_b.start = 1'b0;
        frames_a[0] = 16'h0110; frames_a[1] = 16'h0220; frames_a[2] = 16'h0330;
        frame_b = 16'h0AB0; b_ones = 1'b0;

        repeat (3) @(negedge clk);
        chk("b_rst_cs", bus_b.cs, 1);
        chk("b_rst_scl", bus_b.scl, 1);
        chk("b_rst_out", bus_b.out, 0);
        chk("b_rst_busy", bus_b.busy, 0);
        chk("b_rst_valid", bus_b.valid, 0);
        @(posedge clk); #1 rst_a = 1'b1; rst_b = 1'b1;
        repeat (5) @(negedge clk);
        chk("b_idle_after_rst", bus_b.busy, 0);

        // single start, frame 0x0AB0, CLK_DIV=1
        pulse_b();
        wait_valid_b(200);
        chk("b_out_ab", bus_b.out, 8'hAB);
        chk("b_out_ch0", bus_b.out_ch, 0);
        chk("b_cs_low_33", cslb, 33);
        wait_idle_b(n);
        chk("b_busy_gap", n, 4);
        chk("b_one_valid", vb, 1);

        // sdo held high
        b_ones = 1'b1;
        pulse_b();
        wait_valid_b(200);
        chk("b_out_ff", bus_b.out, 8'hFF);
        chk("b_scl_period", per_b, 2);
        chk("b_cs_low_33b", cslb, 33);
        wait_idle_b(n);
        chk("b_two_valids", vb, 2);

        // continuous sweep over three channels
        @(posedge clk); #1 bus_a.sw = 1'b1;
        n = 0;
        while (vcount_a < 6 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        #1;
        chk("a_six_valids", 32'(vcount_a >= 6), 1);
        chk("a_log_out0", log_out[0], 8'h11);
        chk("a_log_out1", log_out[1], 8'h22);
        chk("a_log_out2", log_out[2], 8'h33);
        chk("a_log_out3", log_out[3], 8'h11);
        chk("a_log_ch0", log_ch[0], 0);
        chk("a_log_ch1", log_ch[1], 1);
        chk("a_log_ch2", log_ch[2], 2);
        chk("a_log_ch3", log_ch[3], 0);

        // drop sw while channel 1 is selected: channel 2 still read, then idle
        n = 0;
        while (bus_a.cs[1] && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk("a_ch1_selected", bus_a.cs, 3'b101);
        bus_a.sw = 1'b0;
        v0 = vcount_a;
        wait_idle_a(1000);
        chk("a_sw_drop_valids", vcount_a - v0, 2);
        chk("a_sw_drop_last_ch", log_ch[log_ch.size() - 1], 2);
        quiet_a("a_quiet_after_sw", 200);

        // start re-pulsed while busy
        v0 = vcount_a;
        pulse_a();
        repeat (20) @(negedge clk);
        pulse_a();
        repeat (100) @(negedge clk);
        pulse_a();
        wait_idle_a(1000);
        chk("a_one_sweep", vcount_a - v0, 3);
        quiet_a("a_no_requeue", 40);

        // reset during bit 7 of channel 0
        v0 = vcount_a;
        pulse_a();
        repeat (2) @(negedge clk);
        n = 0;
        while (rises < 7 && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("a_at_bit7", rises, 7);
        @(posedge clk); #2 rst_a = 1'b0;
        #1;
        chk("a_midrst_cs", bus_a.cs, 3'b111);
        chk("a_midrst_scl", bus_a.scl, 1);
        chk("a_midrst_valid", bus_a.valid, 0);
        chk("a_midrst_busy", bus_a.busy, 0);
        chk("a_midrst_out", bus_a.out, 0);
        repeat (3) @(negedge clk);
        @(posedge clk); #1 rst_a = 1'b1;
        chk("a_midrst_no_valid", vcount_a - v0, 0);
        quiet_a("a_idle_after_rst", 150);
        pulse_a();
        wait_idle_a(1000);
        chk("a_post_rst_sweep", vcount_a - v0, 3);
        chk("a_post_rst_first_ch", log_ch[log_ch.size() - 3], 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
